// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, bit-period divider width and helper.
package uart_pkg;

    localparam int CLK_DIV_W = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        START = 3'b001,
        DATA  = 3'b010,
        STOP  = 3'b011,
        DONE  = 3'b100
    } uart_state_e;

    function automatic int clock_divide(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle done/framing-error pulses.
// Valid/ready: none; done_rx and frame_err are single-cycle strobes with no back-pressure.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_freq  = 50000000,
    parameter int baud_rate = 19200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_data_out,
    output logic        rx_active,
    output logic        done_rx,
    output logic        frame_err,
    output uart_state_e rx_state
);

    localparam int CLK_DIV = clock_divide(clk_freq, baud_rate);
    localparam logic [CLK_DIV_W-1:0] DIV_LAST  = CLK_DIV_W'(CLK_DIV - 1);
    localparam logic [CLK_DIV_W-1:0] HALF_LAST = CLK_DIV_W'(CLK_DIV / 2 - 1);

    logic rx_s;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    uart_state_e          state_reg,     state_next;
    logic [CLK_DIV_W-1:0] clk_div_reg,   clk_div_next;
    logic [2:0]           index_bit_reg, index_bit_next;
    logic [7:0]           rx_data_reg,   rx_data_next;
    logic [7:0]           out_reg,       out_next;
    logic                 err_reg,       err_next;
    logic                 armed_reg,     armed_next;

    always_comb begin
        state_next     = state_reg;
        clk_div_next   = clk_div_reg;
        index_bit_next = index_bit_reg;
        rx_data_next   = rx_data_reg;
        out_next       = out_reg;
        err_next       = err_reg;
        armed_next     = armed_reg;

        case (state_reg)
            IDLE: begin
                clk_div_next   = '0;
                index_bit_next = '0;
                err_next       = 1'b0;
                // armed only re-arms on a high line, so a stuck-low break cannot restart a frame
                if (rx_s) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    armed_next = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (clk_div_reg == HALF_LAST) begin
                    clk_div_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    clk_div_next = clk_div_reg + CLK_DIV_W'(1);
                end
            end
            DATA: begin
                if (clk_div_reg == DIV_LAST) begin
                    clk_div_next                = '0;
                    rx_data_next[index_bit_reg] = rx_s;
                    if (index_bit_reg == 3'd7) begin
                        index_bit_next = '0;
                        state_next     = STOP;
                    end else begin
                        index_bit_next = index_bit_reg + 3'd1;
                    end
                end else begin
                    clk_div_next = clk_div_reg + CLK_DIV_W'(1);
                end
            end
            STOP: begin
                if (clk_div_reg == DIV_LAST) begin
                    clk_div_next = '0;
                    state_next   = DONE;
                    if (rx_s) out_next = rx_data_reg;
                    else      err_next = 1'b1;
                end else begin
                    clk_div_next = clk_div_reg + CLK_DIV_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            clk_div_reg   <= '0;
            index_bit_reg <= '0;
            rx_data_reg   <= '0;
            out_reg       <= '0;
            err_reg       <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clk_div_reg   <= clk_div_next;
            index_bit_reg <= index_bit_next;
            rx_data_reg   <= rx_data_next;
            out_reg       <= out_next;
            err_reg       <= err_next;
            armed_reg     <= armed_next;
        end
    end

    assign rx_data_out = out_reg;
    assign rx_active   = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);
    assign done_rx     = (state_reg == DONE) && !err_reg;
    assign frame_err   = (state_reg == DONE) &&  err_reg;
    assign rx_state    = state_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model with an expected-byte queue.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int CD       = CLK_FREQ / BAUD;
    localparam int LAT_NOM  = (19 * CD) / 2 + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  rx_data_out;
    logic        rx_active;
    logic        done_rx;
    logic        frame_err;
    uart_state_e rx_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // scoreboard: {is_framing_error, byte} per frame, plus pin start cycle for latency
    logic [8:0] exp_q[$];
    int         start_q[$];
    logic [7:0] model_out = 8'h00;
    int done_cnt   = 0;
    int err_cnt    = 0;
    int active_cnt = 0;

    logic [8:0] mon_e;
    int         mon_s;
    int         mon_lat;

    uart_rx #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data_out (rx_data_out),
        .rx_active   (rx_active),
        .done_rx     (done_rx),
        .frame_err   (frame_err),
        .rx_state    (rx_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_level(input logic v, input int n);
        rx = v;
        wait_cycles(n);
    endtask

    // bit length in cycles is CD*den/num, i.e. baud scaled by num/den
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int num, input int den);
        logic [9:0] bits;
        int t;
        int edge_t;
        bits = {stop_bit, data, 1'b0};
        t = 0;
        exp_q.push_back({~stop_bit, data});
        start_q.push_back(cyc);
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            edge_t = ((k + 1) * CD * den) / num;
            wait_cycles(edge_t - t);
            t = edge_t;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        exp_q.delete();
        start_q.delete();
        model_out = 8'h00;
        wait_cycles(1);
        rst = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_active) active_cnt++;
            check("pulse_exclusive", 32'(done_rx & frame_err), 0);
            if (done_rx || frame_err) begin
                check("pulse_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    mon_s = start_q.pop_front();
                    check("pulse_kind_frame_err", 32'(frame_err), 32'(mon_e[8]));
                    if (!mon_e[8]) model_out = mon_e[7:0];
                    check("rx_data_out", 32'(rx_data_out), 32'(model_out));
                    mon_lat = cyc - mon_s;
                    check("latency",
                          (mon_lat >= LAT_NOM - 2 && mon_lat <= LAT_NOM + 2) ? LAT_NOM : mon_lat,
                          LAT_NOM);
                end
                if (done_rx)   done_cnt++;
                if (frame_err) err_cnt++;
            end else begin
                check("rx_data_hold", 32'(rx_data_out), 32'(model_out));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int e0;
        int len;
        int sel;
        int num;
        logic [7:0] b;

        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rx_data_out", 32'(rx_data_out), 0);
        check("reset_rx_active",   32'(rx_active), 0);
        check("reset_done_rx",     32'(done_rx), 0);
        check("reset_frame_err",   32'(frame_err), 0);
        check("reset_state",       32'(rx_state), 32'(IDLE));
        wait_cycles(2 * CD);

        // single frame, as from uart_tx in loopback
        d0 = done_cnt; active_cnt = 0;
        send_frame(8'hA5, 1'b1, 1, 1);
        drive_level(1'b1, CD);
        check("loop_done_count", done_cnt - d0, 1);
        check("loop_rx_data_out", 32'(rx_data_out), 32'h A5);
        check("loop_active_cycles", active_cnt, CD / 2 + 9 * CD);

        // back-to-back patterns, no idle gap
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h00, 1'b1, 1, 1);
        send_frame(8'hFF, 1'b1, 1, 1);
        send_frame(8'h01, 1'b1, 1, 1);
        send_frame(8'h80, 1'b1, 1, 1);
        drive_level(1'b1, CD);
        check("b2b_done_count", done_cnt - d0, 4);
        check("b2b_err_count", err_cnt - e0, 0);

        // short glitch: false start, no pulses
        d0 = done_cnt; e0 = err_cnt; active_cnt = 0;
        len = $urandom_range(3, CD / 2 - 4);
        drive_level(1'b0, len);
        drive_level(1'b1, 2 * CD);
        check("glitch_active_cycles", active_cnt, CD / 2);
        check("glitch_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        check("glitch_state", 32'(rx_state), 32'(IDLE));

        // framing error then held-low break
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 1, 1);
        active_cnt = 0;
        drive_level(1'b0, 3 * CD);
        check("ferr_err_count", err_cnt - e0, 1);
        check("ferr_done_count", done_cnt - d0, 0);
        check("break_active_cycles", active_cnt, 0);
        check("ferr_rx_data_out", 32'(rx_data_out), 32'h80);
        drive_level(1'b1, 2 * CD);
        send_frame(8'h69, 1'b1, 1, 1);
        drive_level(1'b1, CD);
        check("recover_rx_data_out", 32'(rx_data_out), 32'h69);

        // reset during data bit 4 of 0x5A
        d0 = done_cnt; e0 = err_cnt;
        b = 8'h5A;
        drive_level(1'b0, CD);
        for (int k = 0; k < 4; k++) drive_level(b[k], CD);
        drive_level(b[4], CD / 2);
        pulse_reset();
        drive_level(1'b1, 2 * CD);
        check("rst_rx_data_out", 32'(rx_data_out), 0);
        check("rst_state", 32'(rx_state), 32'(IDLE));
        check("rst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        send_frame(8'hC3, 1'b1, 1, 1);
        drive_level(1'b1, CD);
        check("rst_next_rx_data_out", 32'(rx_data_out), 32'hC3);

        // baud skew +/-2%
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h96, 1'b1, 102, 100);
        drive_level(1'b1, CD);
        check("fast_rx_data_out", 32'(rx_data_out), 32'h96);
        send_frame(8'h96, 1'b1, 98, 100);
        drive_level(1'b1, CD);
        check("slow_rx_data_out", 32'(rx_data_out), 32'h96);
        check("skew_done_count", done_cnt - d0, 2);
        check("skew_err_count", err_cnt - e0, 0);

        // randomized frames, skews and gaps
        d0 = done_cnt;
        for (int i = 0; i < 12; i++) begin
            b   = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 2);
            num = (sel == 0) ? 100 : ((sel == 1) ? 102 : 98);
            send_frame(b, 1'b1, num, 100);
            len = $urandom_range(0, CD);
            if (len != 0) drive_level(1'b1, len);
        end
        drive_level(1'b1, 2 * CD);
        check("rand_done_count", done_cnt - d0, 12);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
